// File: rtl/fir_seq_pkg.sv
// Shared definitions for the two-ROM FIR playback sequencer: default widths,
// FSM state encoding and the sample-ROM read latency.
package fir_seq_pkg;

    localparam int NB_DATA_DEF  = 16;
    localparam int NB_DEPTH_DEF = 15;
    localparam int NB_DIV_DEF   = 8;

    // Synchronous ROM: address registered at the end of cycle T, data valid in T+1.
    localparam int ROM_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/fir_seq_tick_gen.sv
// Sample-rate divider: ticks once every (period+1) enabled cycles.
// Latency: tick is combinational from the count; load latches the period and clears the count.
// Backpressure: none; counting simply pauses while i_en is low.
module fir_seq_tick_gen #(
    parameter int NB_DIV = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [NB_DIV-1:0] i_period,
    output logic              o_tick
);

    logic [NB_DIV-1:0] cnt_q, cnt_d;
    logic [NB_DIV-1:0] period_q, period_d;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        o_tick   = i_en && (cnt_q == period_q);
        if (i_load) begin
            period_d = i_period;
            cnt_d    = '0;
        end else if (i_en) begin
            cnt_d = o_tick ? '0 : cnt_q + NB_DIV'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/fir_rom_sequencer.sv
// Playback controller for the MIC1/MIC2 sample ROMs feeding the adaptive FIR; FIR_ROM_SEQ_LOOP_EN enables looped playback.
// Latency: a read tick reaches o_valid 2 cycles later, constant, regardless of divider setting.
// Backpressure: none; the consumer must accept every o_valid, pacing is set only by i_div.
module fir_rom_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NB_DATA      = NB_DATA_DEF,
    parameter int NB_DEPTH     = NB_DEPTH_DEF,
    parameter int NB_DIV       = NB_DIV_DEF,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [NB_DIV-1:0]   i_div,
    input  logic [NB_DEPTH-1:0] i_len,
    output logic [NB_DEPTH-1:0] o_addr,
    input  logic [NB_DATA-1:0]  i_mic1_data,
    input  logic [NB_DATA-1:0]  i_mic2_data,
    output logic [NB_DATA-1:0]  o_d,
    output logic [NB_DATA-1:0]  o_x,
    output logic                o_valid,
    output logic                o_fir_rst,
    output logic                o_busy,
    output logic                o_done
);

    localparam int NB_FCNT = $clog2(FLUSH_CYCLES + 1);

    state_t                state_q, state_d;
    logic [NB_DEPTH-1:0]   addr_q, addr_d;
    logic [NB_DEPTH-1:0]   len_q, len_d;
    logic [NB_FCNT-1:0]    fcnt_q, fcnt_d;
    logic [ROM_LAT-1:0]    pend_q, pend_d;
    logic [ROM_LAT-1:0]    last_q, last_d;
    logic [NB_DATA-1:0]    d_q, d_d;
    logic [NB_DATA-1:0]    x_q, x_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;

    logic start_ok;
    logic tick_en;
    logic tick;
    logic at_len;
    logic stop_play;

    assign start_ok  = (state_q == IDLE) && i_start && !i_stop;
    assign tick_en   = (state_q == PLAY) && !i_stop;
    assign stop_play = (state_q == PLAY) && i_stop;
    assign at_len    = (addr_q == len_q);

    fir_seq_tick_gen #(
        .NB_DIV (NB_DIV)
    ) u_tick_gen (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (start_ok),
        .i_en     (tick_en),
        .i_period (i_div),
        .o_tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        fcnt_d  = fcnt_q;
        pend_d  = pend_q;
        last_d  = last_q;
        d_d     = d_q;
        x_d     = x_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        // Read pipeline tracks which ticks are in flight and whether they carry the len sample.
        pend_d[0] = tick;
        last_d[0] = tick && at_len;
        for (int i = 1; i < ROM_LAT; i++) begin
            pend_d[i] = pend_q[i-1];
            last_d[i] = last_q[i-1] && !stop_play;
        end

        if (pend_q[ROM_LAT-1]) begin
            d_d     = i_mic1_data;
            x_d     = i_mic2_data;
            valid_d = 1'b1;
            // A stop cancels completion credit even for a len sample already in flight.
            done_d  = last_q[ROM_LAT-1] && !stop_play;
        end

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = FLUSH;
                    len_d   = i_len;
                    addr_d  = '0;
                    fcnt_d  = '0;
                    d_d     = '0;
                    x_d     = '0;
                end
            end
            FLUSH: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (fcnt_q == NB_FCNT'(FLUSH_CYCLES - 1)) begin
                    state_d = PLAY;
                end else begin
                    fcnt_d = fcnt_q + NB_FCNT'(1);
                end
            end
            PLAY: begin
                if (i_stop) begin
                    state_d = DRAIN;
                end else if (tick) begin
                    if (at_len) begin
`ifdef FIR_ROM_SEQ_LOOP_EN
                        addr_d = '0;
`else
                        state_d = DRAIN;
`endif
                    end else begin
                        addr_d = addr_q + NB_DEPTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (pend_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            fcnt_q  <= '0;
            pend_q  <= '0;
            last_q  <= '0;
            d_q     <= '0;
            x_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            d_q     <= d_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_addr    = addr_q;
    assign o_d       = d_q;
    assign o_x       = x_q;
    assign o_valid   = valid_q;
    assign o_done    = done_q;
    assign o_busy    = (state_q != IDLE);
    assign o_fir_rst = (state_q == IDLE) || (state_q == FLUSH);

endmodule

// File: tb/tb_fir_rom_sequencer.sv
// Scoreboard bench for fir_rom_sequencer: a run-level model predicts every sample, its cycle and o_done,
// plus the per-cycle o_busy/o_fir_rst profile; a monitor pops and compares on each o_valid.
module tb_fir_rom_sequencer;

    localparam int NB_DATA  = 16;
    localparam int NB_DEPTH = 15;
    localparam int NB_DIV   = 8;
    localparam int FLUSH    = 4;
`ifdef FIR_ROM_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_start;
    logic                i_stop;
    logic [NB_DIV-1:0]   i_div;
    logic [NB_DEPTH-1:0] i_len;
    logic [NB_DEPTH-1:0] o_addr;
    logic [NB_DATA-1:0]  i_mic1_data;
    logic [NB_DATA-1:0]  i_mic2_data;
    logic [NB_DATA-1:0]  o_d;
    logic [NB_DATA-1:0]  o_x;
    logic                o_valid;
    logic                o_fir_rst;
    logic                o_busy;
    logic                o_done;

    fir_rom_sequencer #(
        .NB_DATA      (NB_DATA),
        .NB_DEPTH     (NB_DEPTH),
        .NB_DIV       (NB_DIV),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_div       (i_div),
        .i_len       (i_len),
        .o_addr      (o_addr),
        .i_mic1_data (i_mic1_data),
        .i_mic2_data (i_mic2_data),
        .o_d         (o_d),
        .o_x         (o_x),
        .o_valid     (o_valid),
        .o_fir_rst   (o_fir_rst),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [15:0] base1 = 16'h1000;
    logic [15:0] base2 = 16'h2000;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Sample ROMs: MIC1[k] = base1 + k, MIC2[k] = base2 + k, one-cycle read latency.
    always @(posedge i_clk) begin
        i_mic1_data <= base1 + 16'(o_addr);
        i_mic2_data <= base2 + 16'(o_addr);
    end

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [15:0] x;
        logic        done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(o_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("o_d", 32'(o_d), 32'(mon_e.d));
                    chk("o_x", 32'(o_x), 32'(mon_e.x));
                    chk("o_done", 32'(o_done), 32'(mon_e.done));
                end
            end else begin
                if (o_done) chk("done_without_valid", 32'(o_done), 32'd0);
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    mon_e = sb.pop_front();
                    chk("missed_valid_cycle", 32'(cyc + 1000), 32'(mon_e.cyc));
                end
            end
        end
    end

    // Run-level model: start sampled in cycle s, FLUSH for FLUSH cycles, ticks every div+1
    // cycles from the first PLAY cycle offset by div, each sample visible 2 cycles after its tick.
    task automatic model(input int s, input int div, input int len, input int p,
                         input logic [15:0] b1, input logic [15:0] b2,
                         output int idle, output bit fstop);
        int   tk;
        int   a;
        exp_t e;
        fstop = 1'b0;
        idle  = -1;
        if (p >= 0 && p <= s + FLUSH) begin
            fstop = 1'b1;
            idle  = p + 1;
            return;
        end
        for (int i = 0; ; i++) begin
            tk = s + FLUSH + 1 + div + i * (div + 1);
            if (p >= 0 && tk >= p) break;
            if (!LOOP && i > len) break;
            a      = LOOP ? (i % (len + 1)) : i;
            e.cyc  = tk + 2;
            e.d    = b1 + 16'(a);
            e.x    = b2 + 16'(a);
            e.done = (a == len) && !(LOOP && p == tk + 1);
            sb.push_back(e);
            if (!LOOP && i == len) idle = tk + 3;
        end
        if (idle < 0) idle = p + 2;
    endtask

    task automatic run(input int div, input int len, input int stop_off, input int start_off,
                       input logic [15:0] b1, input logic [15:0] b2);
        int s;
        int p;
        int idle;
        bit fstop;
        int eb;
        int er;
        @(negedge i_clk);
        base1   = b1;
        base2   = b2;
        i_div   = NB_DIV'(div);
        i_len   = NB_DEPTH'(len);
        i_start = 1'b1;
        i_stop  = 1'b0;
        s = cyc;
        p = (stop_off >= 0) ? s + stop_off : -1;
        model(s, div, len, p, b1, b2, idle, fstop);
        for (int k = 1; k <= idle - s + 3; k++) begin
            @(negedge i_clk);
            i_start = (start_off > 0 && k == start_off);
            i_div   = NB_DIV'($urandom);
            i_len   = NB_DEPTH'($urandom);
            eb = (cyc > s && cyc < idle) ? 1 : 0;
            er = (fstop || cyc <= s + FLUSH || cyc >= idle) ? 1 : 0;
            chk("o_busy", 32'(o_busy), 32'(eb));
            chk("o_fir_rst", 32'(o_fir_rst), 32'(er));
            i_stop = (cyc == p);
        end
        i_stop  = 1'b0;
        i_start = 1'b0;
        chk("samples_outstanding", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_d", 32'(o_d), 32'd0);
        chk("rst_x", 32'(o_x), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_fir_rst", 32'(o_fir_rst), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
    endtask

    initial begin
        int s;
        int idle;
        bit fstop;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_div   = '0;
        i_len   = '0;
        repeat (3) @(negedge i_clk);
        chk_reset_vals();
        i_rst_n = 1'b1;
        @(negedge i_clk);

`ifdef FIR_ROM_SEQ_LOOP_EN
        // Looping playback k=0,1,0,1,... with a stop that lands right after a len tick.
        run(0, 1, FLUSH + 1 + 8, -1, 16'h1000, 16'h2000);
        run(2, 3, FLUSH + 30, -1, 16'h1000, 16'h2000);
`else
        run(0, 3, -1, -1, 16'h1000, 16'h2000);
        run(3, 2, -1, -1, 16'h1000, 16'h2000);
        // Stop one cycle after the second tick.
        run(3, 10, FLUSH + 9, -1, 16'h1000, 16'h2000);
        // Start pulse during PLAY is ignored.
        run(1, 5, -1, FLUSH + 3, 16'h3000, 16'h4000);
        run(0, 0, -1, -1, 16'h5000, 16'h6000);
`endif
        // Stop during FLUSH returns to IDLE without any sample.
        run(2, 4, 2, -1, 16'h1000, 16'h2000);
        // Full-depth length is latched; stopped early.
        run(0, (1 << NB_DEPTH) - 1, 30, -1, 16'h7000, 16'h8000);

        // Start together with stop in IDLE: nothing happens.
        @(negedge i_clk);
        i_start = 1'b1;
        i_stop  = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("startstop_busy", 32'(o_busy), 32'd0);
        chk("startstop_fir_rst", 32'(o_fir_rst), 32'd1);
        @(negedge i_clk);
        chk("startstop_busy2", 32'(o_busy), 32'd0);

        // Asynchronous reset mid-PLAY, then replay from address 0.
        @(negedge i_clk);
        base1   = 16'h1000;
        base2   = 16'h2000;
        i_div   = '0;
        i_len   = NB_DEPTH'(20);
        i_start = 1'b1;
        s = cyc;
        model(s, 0, 20, s + FLUSH + 60, 16'h1000, 16'h2000, idle, fstop);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (FLUSH + 6) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_reset_vals();
        sb.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run(0, 3, -1, -1, 16'h1000, 16'h2000);

        // Randomized runs.
        for (int r = 0; r < 16; r++) begin
            int dv;
            int ln;
            int so;
            dv = $urandom_range(0, 4);
            ln = $urandom_range(0, 9);
            if (LOOP) so = $urandom_range(FLUSH + 2, 60);
            else      so = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 40);
            run(dv, ln, so, -1, 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_rom_sequencer.md
Name: fir_rom_sequencer

Overview:
- Playback controller for the two-ROM adaptive-FIR test path.
- Drives the read address shared by the MIC1 (desired, d) and MIC2 (reference, x) sample ROMs and paces reads with a programmable sample-rate divider.
- Registers the paired samples with a valid strobe and sequences the FIR reset: flush before a run, release during the run.
- Sits between the sample ROMs and the adaptive FIR. Start/stop come from VIO/debug logic.

Parameters:
- NB_DATA, 16, sample width.
- NB_DEPTH, 15, ROM address width (2**NB_DEPTH entries).
- NB_DIV, 8, sample-divider width.
- FLUSH_CYCLES, 4, cycles o_fir_rst is held after start before playback; must be ≥1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start pulse; ignored unless IDLE.
- i_stop  in  1  abort request.
- i_div  in  NB_DIV  sample period minus 1; latched at start.
- i_len  in  NB_DEPTH  last address to play; latched at start.
- o_addr  out  NB_DEPTH  ROM read address, shared by both ROMs.
- i_mic1_data  in  NB_DATA  MIC1 ROM data. Synchronous ROM, 1-cycle read latency.
- i_mic2_data  in  NB_DATA  MIC2 ROM data, same timing.
- o_d  out  NB_DATA  registered desired sample, signed.
- o_x  out  NB_DATA  registered reference sample, signed.
- o_valid  out  1  one-cycle strobe; o_d/o_x are new.
- o_fir_rst  out  1  active-high FIR reset.
- o_busy  out  1  high in FLUSH/PLAY/DRAIN.
- o_done  out  1  one-cycle pulse on run completion.

Behaviour:
- Reset values: o_addr=0, o_d=0, o_x=0, o_valid=0, o_fir_rst=1, o_busy=0, o_done=0, state IDLE, divider=0, read pipe empty.
- IDLE:
  - o_fir_rst=1.
  - i_start && !i_stop → FLUSH. Latch i_div and i_len, set o_addr=0, clear divider, zero o_d/o_x.
  - i_start together with i_stop: stop wins, remain IDLE.
- FLUSH:
  - o_fir_rst=1 for exactly FLUSH_CYCLES cycles, then → PLAY with divider=0.
  - i_stop → IDLE immediately.
- PLAY:
  - o_fir_rst=0.
  - Divider counts 0..div_l. Tick when divider==div_l, then divider returns to 0. div_l=0 gives a tick every cycle (fully pipelined).
  - On a tick at cycle T with o_addr=k:
    - The ROM captures k at the end of T; data is valid during T+1.
    - The sequencer captures i_mic1_data/i_mic2_data at the end of T+1.
    - o_valid=1 during T+2, with o_d=MIC1[k] and o_x=MIC2[k].
    - o_addr becomes k+1 at T+1.
  - Latency: tick to o_valid is 2 cycles, constant.
  - Tick with o_addr==len_l: issue that final read, do not increment o_addr, → DRAIN.
  - i_stop in PLAY → DRAIN with no further ticks.
- DRAIN:
  - o_fir_rst=0.
  - Wait for the in-flight read to produce its o_valid. Pending reads always complete, so no sample is lost or duplicated.
  - Then → IDLE. o_done pulses with the last o_valid only on natural completion, never on a stop.
- Address wrap: len_l = 2**NB_DEPTH−1 plays the whole ROM. o_addr never wraps past len_l in non-loop mode.
- Inputs i_div and i_len changing mid-run have no effect; only the values latched at start are used.
- Asynchronous reset mid-run: all outputs return to reset values immediately and any pending read is discarded.
- o_busy = state ≠ IDLE.

Optional Feature:
- Macro FIR_ROM_SEQ_LOOP_EN.
- Defined:
  - A tick at o_addr==len_l sets o_addr=0 and stays in PLAY.
  - The divider is not reset, so pacing stays uniform across the wrap.
  - o_done pulses with the o_valid of each len_l sample.
  - The run ends only via i_stop (→ DRAIN, no o_done).
- Undefined: single pass, as specified above.

Decomposition:
- Package fir_seq_pkg:
  - State encoding localparams: IDLE=2'd0, FLUSH=2'd1, PLAY=2'd2, DRAIN=2'd3.
  - Default widths NB_DATA/NB_DEPTH/NB_DIV.
  - Read-latency constant ROM_LAT=1.
- Sub-module fir_seq_tick_gen: divider with enable/clear and latched period, producing the tick.
- FSM, address counter and sample registers stay in the top.

Test Plan:
- Reset, then i_start with i_div=0, i_len=3, FLUSH_CYCLES=4, ROM MIC1[k]=0x1000+k, MIC2[k]=0x2000+k → o_fir_rst high 4 cycles after start. Then 4 consecutive o_valid carrying (0x1000,0x2000)..(0x1003,0x2003). o_done coincides with the 4th valid; then IDLE, o_fir_rst=1.
- i_div=3, i_len=2 → o_valid spaced exactly 4 cycles apart. First valid comes 2 cycles after the first tick; 3 samples total.
- i_stop 1 cycle after the second tick (i_div=3, i_len=10) → exactly 2 valids, no o_done, o_busy falls after the last valid.
- i_start and i_stop asserted together in IDLE → state unchanged, no o_fir_rst change. i_start during PLAY → ignored, sample sequence unaffected.
- Drop i_rst_n low mid-PLAY → outputs immediately at reset values. A subsequent start replays from address 0.
- With FIR_ROM_SEQ_LOOP_EN, i_div=0, i_len=1 → valids alternate k=0,1,0,1…, o_done on every k=1 valid. i_stop → drain then IDLE, no final o_done.
